// File: rtl/arm_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle ARM control path (states, ALU ops, conditions, mux selects).
// Latency: n/a (types, constants and a combinational decode helper only).
// Backpressure: n/a.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // ALUControl encodings
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_ORR = 4'b0110;
    localparam logic [3:0] ALU_MOV = 4'b1010;

    // Data-processing cmd field, Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Condition codes, Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Instruction classes, Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ResultSrc / ALUSrcB selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    typedef struct packed {
        logic       legal;     // cmd is in the supported subset
        logic       no_write;  // result is not written back (CMP)
        logic       arith;     // ADD/SUB/CMP: C and V are meaningful
        logic [3:0] alu_ctl;
    } dp_dec_t;

    function automatic dp_dec_t dp_decode(input logic [3:0] cmd, input logic s_bit);
        dp_dec_t d;
        d = '{legal: 1'b1, no_write: 1'b0, arith: 1'b0, alu_ctl: ALU_ADD};
        case (cmd)
            CMD_ADD: begin d.alu_ctl = ALU_ADD; d.arith = 1'b1; end
            CMD_SUB: begin d.alu_ctl = ALU_SUB; d.arith = 1'b1; end
            CMD_AND: d.alu_ctl = ALU_AND;
            CMD_ORR: d.alu_ctl = ALU_ORR;
            CMD_MOV: d.alu_ctl = ALU_MOV;
            CMD_CMP: begin
                // CMP only exists with S set; without it the encoding is undefined
                if (s_bit) begin
                    d.alu_ctl  = ALU_SUB;
                    d.arith    = 1'b1;
                    d.no_write = 1'b1;
                end else begin
                    d.legal = 1'b0;
                end
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_cond_unit.sv
// Purpose: evaluates an ARM condition field against registered NZCV.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: i_cond (Instr[31:28]), i_flags (NZCV), o_cond_ex (1 = instruction executes).
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign {w_n, w_z, w_c, w_v} = i_flags;
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = w_ge;
            COND_LT: o_cond_ex = ~w_ge;
            COND_GT: o_cond_ex = ~w_z & w_ge;
            COND_LE: o_cond_ex = w_z | ~w_ge;
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;  // 1111 is treated as never
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Purpose: multicycle ARM sequencer; walks each instruction through shared ALU/memory states, owns NZCV.
// Latency: DP 4 (CMP 3), LDR 5, STR 4, B 3, cond-fail 2 cycles; +1 per MemReady=0 cycle in FETCH/MEMRD/MEMWR.
// Backpressure: stalls in FETCH/MEMRD/MEMWR until MemReady; MemWrite held across the stall.
// Ports: clk, reset (async active-low); Cond/Op/Funct/Rd from IR; ALUFlags, MemReady from datapath;
//        enables PCWrite/IRWrite/RegWrite/MemWrite; selects AdrSrc/ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/RegSrc;
//        ALUControl; Flags (registered NZCV); State (debug).
module multicycle_ctrl_fsm
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic       w_cond_ex;
    dp_dec_t    w_dp;
    logic       w_rd_pc;
    logic       w_flag_upd;
    logic       w_pcwrite, w_irwrite, w_regwrite, w_memwrite;

    cond_unit u_cond (
        .i_cond    (Cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    assign w_dp    = dp_decode(Funct[4:1], Funct[0]);
    assign w_rd_pc = (Rd == 4'd15);

    // Flags move on the execute edge only for a taken, legal, S-suffixed op
    assign w_flag_upd = ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) &&
                        r_cond_ex && Funct[0] && w_dp.legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cond_ex <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_cond_ex <= w_cond_ex;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (w_flag_upd) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_dp.arith) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (MemReady) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC+4 again so R15 reads as PC+8 during register read
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (!w_cond_ex) begin
                    w_next = S_FETCH;
                end else begin
                    case (Op)
                        OP_MEM:  w_next = S_MEMADR;
                        OP_DP:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                        OP_BR:   w_next = S_BRANCH;
                        default: w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                w_regwrite = r_cond_ex;
                w_pcwrite  = r_cond_ex & w_rd_pc;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                w_memwrite = r_cond_ex;
                if (MemReady) begin
                    w_next = S_FETCH;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = (r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_RD2;
                ALUControl = w_dp.alu_ctl;
                w_next     = (w_dp.legal && !w_dp.no_write) ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                w_regwrite = r_cond_ex;
                w_pcwrite  = r_cond_ex & w_rd_pc;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                w_pcwrite = r_cond_ex;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Enables are qualified by reset so a mid-access reset drops them in the same cycle
    assign PCWrite  = reset & w_pcwrite;
    assign IRWrite  = reset & w_irwrite;
    assign RegWrite = reset & w_regwrite;
    assign MemWrite = reset & w_memwrite;

    assign ImmSrc = (Op == 2'b11) ? 2'b00 : Op;
    assign RegSrc = {(Op == OP_MEM), (Op == OP_BR)};
    assign Flags  = r_flags;
    assign State  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0] ALUControl, Flags, State;

    multicycle_ctrl_fsm dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .Flags(Flags), .State(State)
    );

    always #5 clk = ~clk;

    // Per-instruction observation: counts from the IRWrite cycle up to the next FETCH
    typedef struct {
        int         lat, irw, pcw, rgw, mww, spur, fetch_bad;
        logic [3:0] flags, alu;
        logic [1:0] wbs, srcb;
    } rec_t;

    rec_t       exp_q[$];
    rec_t       cur;
    bit         in_rec;
    int         spur_acc;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] flags_m = 4'b0000;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic finalize();
        rec_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_instr", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("latency",     cur.lat,       e.lat);
        chk("irwrite_cnt", cur.irw,       e.irw);
        chk("pcwrite_cnt", cur.pcw,       e.pcw);
        chk("regwrite_cnt",cur.rgw,       e.rgw);
        chk("memwrite_cnt",cur.mww,       e.mww);
        chk("spurious_en", cur.spur,      0);
        chk("fetch_sel",   cur.fetch_bad, 0);
        chk("flags",       cur.flags,     e.flags);
        chk("alu_ctl",     cur.alu,       e.alu);
        chk("wb_src",      cur.wbs,       e.wbs);
        chk("alu_srcb",    cur.srcb,      e.srcb);
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge
    initial begin
        in_rec = 0; spur_acc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_rec = 0; spur_acc = 0;
            end else begin
                if (in_rec && State == 4'd0) begin
                    cur.flags = Flags;
                    finalize();
                    in_rec = 0;
                end
                if (!in_rec) begin
                    if (IRWrite) begin
                        cur.lat = 0; cur.irw = 0; cur.pcw = 0; cur.rgw = 0; cur.mww = 0;
                        cur.spur = spur_acc; spur_acc = 0;
                        cur.alu = 4'd0; cur.wbs = 2'b11; cur.srcb = 2'b11;
                        cur.fetch_bad = (ALUSrcA != 1'b1 || ALUSrcB != 2'b10 ||
                                         AdrSrc != 1'b0 || ResultSrc != 2'b10) ? 1 : 0;
                        in_rec = 1;
                    end else if (PCWrite || RegWrite || MemWrite) begin
                        spur_acc++;
                    end
                end
                if (in_rec) begin
                    if (cur.lat == 2) begin
                        cur.alu  = ALUControl;
                        cur.srcb = ALUSrcB;
                    end
                    cur.lat++;
                    cur.irw += int'(IRWrite);
                    cur.pcw += int'(PCWrite);
                    cur.rgw += int'(RegWrite);
                    if (MemWrite) begin
                        cur.mww++;
                        if (!AdrSrc) cur.spur++;
                    end
                    if (RegWrite) cur.wbs = ResultSrc;
                end
            end
        end
    end

    // Drives one instruction; fs = fetch stall cycles, ms = memory stall cycles, abort_at >= 0 resets mid-flight
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input logic [3:0] af,
                             input int fs, input int ms, input int abort_at);
        rec_t e;
        bit   ce, mem, legal, nowr, arith;
        logic [3:0] alu;
        ce  = cond_ok(c, flags_m);
        mem = ce && (op == 2'b01);
        e.irw = 1; e.pcw = 1; e.rgw = 0; e.mww = 0; e.spur = 0; e.fetch_bad = 0;
        e.alu = 4'd0; e.wbs = 2'b11; e.srcb = 2'b11;
        if (!ce || op == 2'b11) begin
            e.lat = 2;
        end else if (op == 2'b01) begin
            e.srcb = 2'b01;
            if (fn[0]) begin
                e.lat = ms + 5; e.rgw = 1; e.wbs = 2'b01; e.pcw += (rd == 4'd15) ? 1 : 0;
            end else begin
                e.lat = ms + 4; e.mww = ms + 1;
            end
        end else if (op == 2'b10) begin
            e.lat = 3; e.pcw = 2; e.srcb = 2'b01;
        end else begin
            legal = 1; nowr = 0; arith = 0; alu = 4'b0000;
            case (fn[4:1])
                4'b0100: begin alu = 4'b0000; arith = 1; end
                4'b0010: begin alu = 4'b0001; arith = 1; end
                4'b0000: alu = 4'b0101;
                4'b1100: alu = 4'b0110;
                4'b1101: alu = 4'b1010;
                4'b1010: if (fn[0]) begin alu = 4'b0001; arith = 1; nowr = 1; end else legal = 0;
                default: legal = 0;
            endcase
            e.alu  = legal ? alu : 4'b0000;
            e.srcb = fn[5] ? 2'b01 : 2'b00;
            if (legal && !nowr) begin
                e.lat = 4; e.rgw = 1; e.wbs = 2'b00; e.pcw += (rd == 4'd15) ? 1 : 0;
            end else begin
                e.lat = 3;
            end
            if (legal && fn[0]) begin
                flags_m[3:2] = af[3:2];
                if (arith) flags_m[1:0] = af[1:0];
            end
        end
        e.flags = flags_m;
        if (abort_at < 0) exp_q.push_back(e);

        for (int cyc = 0; cyc < fs + e.lat; cyc++) begin
            @(posedge clk);
            #1;
            Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
            if (cyc < fs)                                      MemReady = 1'b0;
            else if (cyc == fs)                                MemReady = 1'b1;
            else if (mem && cyc >= fs + 3 && cyc < fs + 3 + ms) MemReady = 1'b0;
            else if (mem && cyc == fs + 3 + ms)                MemReady = 1'b1;
            else                                               MemReady = 1'($urandom_range(0, 1));
            if (cyc == fs + 1 && op != 2'b11) begin
                #1;
                chk("imm_src", ImmSrc, op);
                chk("reg_src", RegSrc, {op == 2'b01, op == 2'b10});
            end
            if (cyc == abort_at) begin
                MemReady = 1'b0;
                #1;
                chk("memwrite_before_rst", MemWrite, 1);
                reset = 1'b0;
                #1;
                chk("rst_memwrite", MemWrite, 0);
                chk("rst_state", State, 0);
                chk("rst_flags", Flags, 0);
                chk("rst_regwrite", RegWrite, 0);
                flags_m = 4'b0000;
                @(posedge clk);
                #2 reset = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [3:0] cmds [6];
        logic [3:0] rc, rrd;
        logic [1:0] rop;
        logic [5:0] rfn;
        int         r;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b1010};
        reset = 1'b0; Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        MemReady = 1'b1;
        #12;
        chk("reset_state", State, 0);
        chk("reset_flags", Flags, 0);
        chk("reset_irwrite", IRWrite, 0);
        chk("reset_pcwrite", PCWrite, 0);
        MemReady = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;

        run_instr(4'b1110, 2'b00, 6'b001001, 4'd1,  4'b1011, 0, 0, -1); // ADDS R1
        run_instr(4'b1110, 2'b00, 6'b010101, 4'd0,  4'b0100, 1, 0, -1); // CMP -> Z
        run_instr(4'b0000, 2'b10, 6'b000000, 4'd0,  4'b0000, 0, 0, -1); // BEQ taken
        run_instr(4'b0001, 2'b10, 6'b000000, 4'd0,  4'b0000, 0, 0, -1); // BNE not taken
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd2,  4'b0000, 0, 3, -1); // LDR, 3 stalls
        run_instr(4'b1110, 2'b00, 6'b011010, 4'd15, 4'b1111, 0, 0, -1); // MOV PC
        run_instr(4'b1110, 2'b01, 6'b011000, 4'd3,  4'b0000, 0, 2, 4);  // STR, reset in MEMWR
        run_instr(4'b1111, 2'b00, 6'b001001, 4'd1,  4'b1111, 0, 0, -1); // cond 1111 never

        for (int i = 0; i < 120; i++) begin
            r   = $urandom_range(0, 9);
            rop = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            rc  = ($urandom_range(0, 1) == 1) ? 4'b1110 : 4'($urandom_range(0, 15));
            rfn = 6'($urandom_range(0, 63));
            if (rop == 2'b00 && $urandom_range(0, 4) != 0)
                rfn[4:1] = cmds[$urandom_range(0, 5)];
            rrd = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            run_instr(rc, rop, rfn, rrd, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        @(posedge clk);
        #1 MemReady = 1'b0;
        for (int k = 0; k < 50 && (exp_q.size() != 0 || in_rec); k++) @(posedge clk);
        chk("drain_pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
